// File: rtl/traffic_pkg.sv
// Shared lamp and state encodings for the two-road traffic light controller.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Road A is only ever non-red in S0/S1, road B only in S2/S3.
  function automatic logic [1:0] lamp_a(input state_t s);
    case (s)
      S0:      return GREEN;
      S1:      return YELLOW;
      default: return RED;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input state_t s);
    case (s)
      S2:      return GREEN;
      S3:      return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Tick/sensor inputs and lamp/phase outputs of the traffic light controller.
interface traffic_light_fsm_if;
  logic       tick;
  logic       ta;
  logic       tb;
  logic [1:0] la;
  logic [1:0] lb;
  logic [1:0] phase;
  logic       phase_change;

  modport master (output tick, ta, tb, input la, lb, phase, phase_change);
  modport slave  (input tick, ta, tb, output la, lb, phase, phase_change);
endinterface

// File: rtl/tick_timer.sv
// Saturating tick counter: clear wins over enable, counting stops at i_max.
module tick_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Tick count held in the current phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (i_clr) begin
      r_count <= {W{1'b0}};
    end else if (i_en && (r_count < i_max)) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller advancing only on upstream tick pulses;
// green is held while the road sensor reports traffic.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_TICKS = 3,
  parameter int YELLOW_TICKS    = 2
) (
  input logic               clk,
  input logic               rst,
  traffic_light_fsm_if.slave bus
);

  localparam int TMAX = (MIN_GREEN_TICKS > YELLOW_TICKS) ? MIN_GREEN_TICKS : YELLOW_TICKS;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] GREEN_LAST  = TW'(MIN_GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_la;
  logic [1:0]      r_lb;
  logic            r_chg;
  logic            r_pc;
  logic            w_trans;
  logic [TW-1:0]   w_max;
  logic [TW-1:0]   w_count;

  tick_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_trans),
    .i_en    (bus.tick),
    .i_max   (w_max),
    .o_count (w_count)
  );

  // Next-state decision and per-phase saturation limit
  always_comb begin
    w_next = r_state;
    w_max  = GREEN_LAST;
    case (r_state)
      S0: begin
        w_max = GREEN_LAST;
        if (bus.tick && (w_count >= GREEN_LAST) && !bus.ta) w_next = S1;
        else w_next = S0;
      end
      S1: begin
        w_max = YELLOW_LAST;
        if (bus.tick && (w_count == YELLOW_LAST)) w_next = S2;
        else w_next = S1;
      end
      S2: begin
        w_max = GREEN_LAST;
        if (bus.tick && (w_count >= GREEN_LAST) && !bus.tb) w_next = S3;
        else w_next = S2;
      end
      S3: begin
        w_max = YELLOW_LAST;
        if (bus.tick && (w_count == YELLOW_LAST)) w_next = S0;
        else w_next = S3;
      end
      default: begin
        w_max  = GREEN_LAST;
        w_next = S0;
      end
    endcase
    w_trans = (w_next != r_state);
  end

  // State and lamp registers; phase_change trails the transition edge by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_la    <= GREEN;
      r_lb    <= RED;
      r_chg   <= 1'b0;
      r_pc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_la    <= lamp_a(w_next);
      r_lb    <= lamp_b(w_next);
      r_chg   <= w_trans;
      r_pc    <= r_chg;
    end
  end

  assign bus.la           = r_la;
  assign bus.lb           = r_lb;
  assign bus.phase        = r_state;
  assign bus.phase_change = r_pc;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed scenarios feed a queue of expected phase entries; a negedge monitor
// detects each phase change and checks it against the queue.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  typedef struct {
    logic [1:0] ph;
    int         dwell;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];

  traffic_light_fsm_if bus();

  traffic_light_fsm #(.MIN_GREEN_TICKS(3), .YELLOW_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] ref_la(input logic [1:0] ph);
    case (ph)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] ref_lb(input logic [1:0] ph);
    case (ph)
      2'b10:   return 2'b00;
      2'b11:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic step(input logic t, input logic a, input logic b);
    bus.tick = t;
    bus.ta   = a;
    bus.tb   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic tick3(input logic a, input logic b);
    step(1'b0, a, b);
    step(1'b0, a, b);
    step(1'b1, a, b);
  endtask

  task automatic push(input logic [1:0] ph, input int dwell);
    exp_t e;
    e.ph    = ph;
    e.dwell = dwell;
    q.push_back(e);
  endtask

  // Monitor: tick counting per phase, transition scoreboard, pulse and safety checks
  initial begin
    bit         prev_rst;
    bit         chg_d;
    logic [1:0] prev_ph;
    int         cnt;
    exp_t       e;
    prev_rst = 1'b1;
    chg_d    = 1'b0;
    prev_ph  = 2'b00;
    cnt      = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("safety", int'((bus.la == 2'b10) || (bus.lb == 2'b10)), 1);
      if (prev_rst) begin
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_la", int'(bus.la), 0);
        chk("rst_lb", int'(bus.lb), 2);
        chk("rst_pc", int'(bus.phase_change), 0);
        cnt     = 0;
        chg_d   = 1'b0;
        prev_ph = 2'b00;
      end else begin
        chk("phase_change", int'(bus.phase_change), int'(chg_d));
        if (bus.phase != prev_ph) begin
          if (q.size() == 0) begin
            chk("unexpected_transition", int'(bus.phase), int'(prev_ph));
          end else begin
            e = q.pop_front();
            chk("new_phase", int'(bus.phase), int'(e.ph));
            chk("dwell_ticks", cnt, e.dwell);
            chk("la", int'(bus.la), int'(ref_la(e.ph)));
            chk("lb", int'(bus.lb), int'(ref_lb(e.ph)));
          end
          cnt     = 0;
          chg_d   = 1'b1;
          prev_ph = bus.phase;
        end else begin
          chg_d = 1'b0;
        end
      end
      prev_rst = rst;
      if (!rst && bus.tick) cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.tick = 1'b0;
    bus.ta   = 1'b1;
    bus.tb   = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Nominal full cycle: 3/2/3/2 ticks
    push(2'b01, 3);
    push(2'b10, 2);
    push(2'b11, 3);
    push(2'b00, 2);
    repeat (10) tick3(1'b0, 1'b0);

    // Green extension on road A
    push(2'b01, 7);
    repeat (6) tick3(1'b1, 1'b0);
    tick3(1'b0, 1'b0);

    // Tick gating in S1 with sensors toggling
    for (int i = 0; i < 20; i++) step(1'b0, i[0], ~i[0]);
    push(2'b10, 2);
    repeat (2) tick3(1'b0, 1'b0);

    // Road B sensor drops only between ticks
    push(2'b11, 6);
    repeat (5) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
    end
    tick3(1'b0, 1'b0);

    // Reset in S3 coincident with a tick, then a fresh 3-tick green
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    push(2'b01, 3);
    repeat (3) tick3(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
